// File: rtl/qynq_led_ctrl.sv
// Multi-channel LED controller: per-channel off/on/blink/PWM/breathe modes,
// configured through a single-cycle write strobe, shared tick/blink/PWM timebase.
module qynq_led_ctrl #(
    parameter int unsigned LED_NUM     = 4,
    parameter int unsigned PWM_BITS    = 8,
    parameter int unsigned TICK_DIV    = 100000,
    parameter int unsigned BLINK_TICKS = 500,
    localparam int unsigned CH_W       = (LED_NUM > 1) ? $clog2(LED_NUM) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                led_en,
    input  logic                cfg_wr,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [2:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic [LED_NUM-1:0]  led_o,
    output logic                tick_o
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam int unsigned BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PWM_BITS-1:0] LVL_TOP = '1;

    typedef enum logic [2:0] {
        MODE_OFF     = 3'd0,
        MODE_ON      = 3'd1,
        MODE_BLINK   = 3'd2,
        MODE_PWM     = 3'd3,
        MODE_BREATHE = 3'd4
    } mode_e;

    logic [PRE_W-1:0]    r_presc;
    logic                r_tick;
    logic [BLK_W-1:0]    r_blk_cnt;
    logic                r_phase;
    logic [PWM_BITS-1:0] r_pwm;
    mode_e               r_mode   [LED_NUM];
    logic [PWM_BITS-1:0] r_duty   [LED_NUM];
    logic [PWM_BITS-1:0] r_level  [LED_NUM];
    logic                r_dir_dn [LED_NUM];
    logic [LED_NUM-1:0]  r_led;
    logic [LED_NUM-1:0]  w_next;

    always_comb begin
        w_next = '0;
        for (int unsigned i = 0; i < LED_NUM; i++) begin
            case (r_mode[i])
                MODE_ON:      w_next[i] = 1'b1;
                MODE_BLINK:   w_next[i] = r_phase;
                MODE_PWM:     w_next[i] = (r_pwm < r_duty[i]);
                MODE_BREATHE: w_next[i] = (r_pwm < r_level[i]);
                default:      w_next[i] = 1'b0;
            endcase
        end
    end

    // r_tick is set one count early so it is high exactly while r_presc == TICK_DIV-1;
    // it therefore doubles as the internal tick event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_tick    <= 1'b0;
            r_blk_cnt <= '0;
            r_phase   <= 1'b0;
            r_pwm     <= '0;
            r_led     <= '0;
            for (int unsigned i = 0; i < LED_NUM; i++) begin
                r_mode[i]   <= MODE_OFF;
                r_duty[i]   <= '0;
                r_level[i]  <= '0;
                r_dir_dn[i] <= 1'b0;
            end
        end else begin
            r_presc <= (r_presc == PRE_W'(TICK_DIV - 1)) ? '0 : r_presc + 1'b1;
            r_tick  <= (r_presc == PRE_W'(TICK_DIV - 2));
            r_pwm   <= r_pwm + 1'b1;

            if (r_tick) begin
                if (r_blk_cnt == BLK_W'(BLINK_TICKS - 1)) begin
                    r_blk_cnt <= '0;
                    r_phase   <= ~r_phase;
                end else begin
                    r_blk_cnt <= r_blk_cnt + 1'b1;
                end
            end

            // Only in-range indices can match, so out-of-range writes fall through untouched.
            for (int unsigned i = 0; i < LED_NUM; i++) begin
                if (cfg_wr && (cfg_ch == CH_W'(i))) begin
                    r_mode[i]   <= mode_e'(cfg_mode);
                    r_duty[i]   <= cfg_duty;
                    r_level[i]  <= '0;
                    r_dir_dn[i] <= 1'b0;
                end else if (r_tick && (r_mode[i] == MODE_BREATHE)) begin
                    if (!r_dir_dn[i]) begin
                        r_level[i] <= r_level[i] + 1'b1;
                        if (r_level[i] == LVL_TOP - 1'b1)
                            r_dir_dn[i] <= 1'b1;
                    end else begin
                        r_level[i] <= r_level[i] - 1'b1;
                        if (r_level[i] == PWM_BITS'(1))
                            r_dir_dn[i] <= 1'b0;
                    end
                end
            end

            r_led <= w_next & {LED_NUM{led_en}};
        end
    end

    assign led_o  = r_led;
    assign tick_o = r_tick;

endmodule
